// File: rtl/shift_unit_iter.sv
// Iterative barrel shifter (SLL/SRL/SRA/ROR). It resolves STAGES_PER_CYCLE log2 stages
// per clock, MSB stage first, and uses valid/ready handshakes on input and output.
module shift_unit_iter #(
    parameter int WIDTH            = 32,
    parameter int SHAMT_W          = 5,
    parameter int STAGES_PER_CYCLE = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data
);
    localparam int NUM_STEPS = (SHAMT_W + STAGES_PER_CYCLE - 1) / STAGES_PER_CYCLE;
    localparam int STEP_W    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic [SHAMT_W-1:0]  shamt_q, shamt_d;
    logic [1:0]          mode_q, mode_d;
    logic [WIDTH-1:0]    out_data_q, out_data_d;

    // chain[SHAMT_W] is the partial result. Each stage applies its fixed shift only
    // when its own step is current and its shamt bit is set. Otherwise it passes the value through.
    logic [WIDTH-1:0] chain [0:SHAMT_W];
    assign chain[SHAMT_W] = data_q;

    for (genvar gi = 0; gi < SHAMT_W; gi++) begin : g_stage
        localparam int AMT = 1 << gi;
        localparam logic [STEP_W-1:0] OWN_STEP = STEP_W'((SHAMT_W - 1 - gi) / STAGES_PER_CYCLE);
        logic [WIDTH-1:0] shifted;

        always_comb begin
            unique case (mode_q)
                2'b00:   shifted = chain[gi+1] << AMT;
                2'b01:   shifted = chain[gi+1] >> AMT;
                2'b10:   shifted = $signed(chain[gi+1]) >>> AMT;
                default: shifted = (chain[gi+1] >> AMT) | (chain[gi+1] << (WIDTH - AMT));
            endcase
        end

        assign chain[gi] = (shamt_q[gi] && (step_q == OWN_STEP)) ? shifted : chain[gi+1];
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            step_q     <= '0;
            data_q     <= '0;
            shamt_q    <= '0;
            mode_q     <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            data_q     <= data_d;
            shamt_q    <= shamt_d;
            mode_q     <= mode_d;
            out_data_q <= out_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        data_d     = data_q;
        shamt_d    = shamt_q;
        mode_d     = mode_q;
        out_data_d = out_data_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    shamt_d = in_shamt;
                    mode_d  = in_mode;
                    step_d  = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                data_d = chain[0];
                step_d = step_q + STEP_W'(1);
                if (step_q == LAST_STEP) begin
                    out_data_d = chain[0];
                    step_d     = '0;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Flush drops the op. out_data keeps its last value, but out_valid will not assert for it.
        if (flush) begin
            state_d = S_IDLE;
            step_d  = '0;
        end
    end

    assign in_ready  = reset_n && (state_q == S_IDLE);
    assign out_valid = reset_n && (state_q == S_DONE);
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_shift_unit_iter.sv
// Scoreboard bench for shift_unit_iter. The driver pushes the expected result and the expected valid
// cycle into a queue. The negedge monitor pops an entry on each output handshake and compares it.
module tb_shift_unit_iter;
    localparam int NUM_STEPS = 3;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] in_data = '0;
    logic [4:0]  in_shamt = '0;
    logic [1:0]  in_mode = '0;
    logic        in_ready, out_valid;
    logic [31:0] out_data;

    shift_unit_iter #(.WIDTH(32), .SHAMT_W(5), .STAGES_PER_CYCLE(2)) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shamt(in_shamt), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        int          exp_cyc;
        string       name;
    } exp_t;
    exp_t sb[$];

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s, input logic [1:0] m);
        case (m)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return $signed(d) >>> s;
            default: return (s == 0) ? d : ((d >> s) | (d << (32 - s)));
        endcase
    endfunction

    // Monitor
    logic        prev_valid = 1'b0;
    logic [31:0] held = '0;
    int          rise_cyc = 0;
    exp_t        mon_e;
    always @(negedge clock) begin
        if (out_valid && prev_valid) chk("hold_data", out_data, held);
        if (out_valid && !prev_valid) rise_cyc = cyc;
        if (out_valid) held = out_data;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                $display("txn %s: out_data=0x%08h expected=0x%08h valid_cycle=%0d", mon_e.name, out_data, mon_e.data, rise_cyc);
                chk(mon_e.name, out_data, mon_e.data);
                chk({mon_e.name, "_latency"}, 32'(rise_cyc), 32'(mon_e.exp_cyc));
            end
        end
        prev_valid = out_valid;
    end

    task automatic issue(input logic [31:0] d, input logic [4:0] s, input logic [1:0] m,
                         input logic [31:0] exp, input string name, input bit push);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        if (!in_ready) begin
            chk({name, "_ready_timeout"}, 32'd0, 32'd1);
            return;
        end
        in_data = d; in_shamt = s; in_mode = m; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        in_shamt = 5'($urandom);
        in_mode  = 2'($urandom);
        chk({name, "_accepted"}, 32'(in_ready), 32'd0);
        if (push) sb.push_back('{exp, cyc + NUM_STEPS, name});
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        if (sb.size() != 0 || !in_ready) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        if (!out_valid) chk({name, "_valid_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clock); #1;
            if (out_valid) seen++;
        end
        chk(name, 32'(seen), 32'd0);
    endtask

    initial begin
        logic [31:0] pat;
        pat = 32'h9ABC0123;

        repeat (3) @(posedge clock);
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", out_data, 32'd0);
        reset_n = 1'b1;
        #1;
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        issue(32'h80000000, 5'd31, 2'b10, 32'hFFFFFFFF, "sra_msb31", 1'b1);
        issue(32'h80000000, 5'd31, 2'b01, 32'h00000001, "srl31", 1'b1);
        issue(32'h00000001, 5'd31, 2'b00, 32'h80000000, "sll31", 1'b1);
        issue(32'h7FFFFFF0, 5'd4,  2'b10, 32'h07FFFFFF, "sra4", 1'b1);
        issue(32'h12345678, 5'd8,  2'b11, 32'h78123456, "ror8", 1'b1);
        issue(32'h12345678, 5'd0,  2'b11, 32'h12345678, "ror0", 1'b1);
        issue(32'hDEADBEEF, 5'd0,  2'b00, 32'hDEADBEEF, "sll0", 1'b1);
        issue(32'hF0000000, 5'd1,  2'b10, 32'hF8000000, "sra1", 1'b1);
        issue(32'h00000003, 5'd1,  2'b11, 32'h80000001, "ror1", 1'b1);
        drain();

        for (int s = 0; s < 32; s++) begin
            issue(32'h80000000, 5'(s), 2'b01, ref_shift(32'h80000000, s, 2'b01), $sformatf("srl_s%0d", s), 1'b1);
            issue(32'h00000001, 5'(s), 2'b00, ref_shift(32'h00000001, s, 2'b00), $sformatf("sll_s%0d", s), 1'b1);
            issue(pat, 5'(s), 2'b10, ref_shift(pat, s, 2'b10), $sformatf("sra_s%0d", s), 1'b1);
            issue(pat, 5'(s), 2'b11, ref_shift(pat, s, 2'b11), $sformatf("ror_s%0d", s), 1'b1);
        end
        drain();

        // Backpressure in DONE
        out_ready = 1'b0;
        issue(32'hA5A50F0F, 5'd12, 2'b01, 32'h000A5A50, "bp_srl12", 1'b1);
        wait_valid("bp");
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            chk("bp_valid_held", 32'(out_valid), 32'd1);
            chk("bp_data_held", out_data, 32'h000A5A50);
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        drain();

        // Reset asserted for a single edge while SHIFT is at step 1
        issue(32'h0000FFFF, 5'd3, 2'b00, 32'h0, "rst_victim", 1'b0);
        @(posedge clock); #1;
        reset_n = 1'b0;
        @(posedge clock); #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data", out_data, 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        reset_n = 1'b1;
        #1;
        chk("postrst_in_ready", 32'(in_ready), 32'd1);
        issue(32'h0000FFFF, 5'd3, 2'b00, 32'h0007FFF8, "postrst_sll3", 1'b1);
        drain();

        // Flush during SHIFT
        issue(32'hCAFEBABE, 5'd5, 2'b01, 32'h0, "flush_shift_victim", 1'b0);
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        chk("flush_shift_in_ready", 32'(in_ready), 32'd1);
        chk("flush_shift_out_valid", 32'(out_valid), 32'd0);
        expect_quiet("flush_shift_no_valid", 6);

        // Flush in DONE with the result still held
        out_ready = 1'b0;
        issue(32'hCAFEBABE, 5'd4, 2'b11, 32'hECAFEBAB, "flush_done_op", 1'b1);
        wait_valid("flush_done");
        chk("flush_done_pre_data", out_data, 32'hECAFEBAB);
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        chk("flush_done_out_valid", 32'(out_valid), 32'd0);
        chk("flush_done_in_ready", 32'(in_ready), 32'd1);
        if (sb.size() != 0) void'(sb.pop_front());
        out_ready = 1'b1;
        expect_quiet("flush_done_no_valid", 6);

        // Flush in IDLE with in_valid high: the op must not be accepted
        in_data = 32'h11112222; in_shamt = 5'd2; in_mode = 2'b00;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_idle_in_ready", 32'(in_ready), 32'd1);
        expect_quiet("flush_idle_no_valid", 6);

        issue(32'h11112222, 5'd2, 2'b00, 32'h44448888, "final_sll2", 1'b1);
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
